// File: rtl/dma_pkg.sv
// Shared constants and FSM state type for the DMA read path.
package dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         BEAT_BYTES     = 8;
    localparam int         BOUNDARY_BEATS = 512;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/dma_read_scheduler_if.sv
// AXI3 ACP read-address channel plus the observed read-data handshake.
interface dma_read_scheduler_if #(
    parameter int ADDR_W = 32
);

    logic [ADDR_W-1:0] m_axi_acp_araddr;
    logic [3:0]        m_axi_acp_arlen;
    logic [1:0]        m_axi_acp_arburst;
    logic              m_axi_acp_arvalid;
    logic              m_axi_acp_arready;
    logic              m_axi_acp_rvalid;
    logic              m_axi_acp_rready;
    logic              m_axi_acp_rlast;
    logic [1:0]        m_axi_acp_rresp;

    modport master (
        output m_axi_acp_araddr, m_axi_acp_arlen, m_axi_acp_arburst, m_axi_acp_arvalid,
        input  m_axi_acp_arready,
        input  m_axi_acp_rvalid, m_axi_acp_rready, m_axi_acp_rlast, m_axi_acp_rresp
    );

    modport slave (
        input  m_axi_acp_araddr, m_axi_acp_arlen, m_axi_acp_arburst, m_axi_acp_arvalid,
        output m_axi_acp_arready,
        output m_axi_acp_rvalid, m_axi_acp_rready, m_axi_acp_rlast, m_axi_acp_rresp
    );

endinterface

// File: rtl/dma_burst_sizer.sv
// Burst length = min(remaining beats, MAX_BURST, beats left before the next 4 KB boundary).
module dma_burst_sizer
    import dma_pkg::*;
#(
    parameter int LEN_W     = 20,
    parameter int MAX_BURST = 16
) (
    input  logic [8:0]       beat_idx,
    input  logic [LEN_W-1:0] remaining,
    output logic [4:0]       len
);

    logic [LEN_W-1:0] to_boundary;
    logic [LEN_W-1:0] cap;

    always_comb begin
        to_boundary = LEN_W'(BOUNDARY_BEATS) - LEN_W'(beat_idx);
        cap         = (to_boundary < LEN_W'(MAX_BURST)) ? to_boundary : LEN_W'(MAX_BURST);
        len         = (remaining < cap) ? 5'(remaining) : 5'(cap);
    end

endmodule

// File: rtl/dma_read_scheduler.sv
// Splits one DMA read command into 4 KB-safe INCR bursts on the ACP AR channel and
// tracks outstanding bursts by watching rlast handshakes.
module dma_read_scheduler
    import dma_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 20,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 m_axi_acp_aclk,
    input  logic                 axi_resetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [LEN_W-1:0]     cmd_beats,
    dma_read_scheduler_if.master axi,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [3:0]        outstanding_q, outstanding_d;
    logic              err_q, err_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [3:0]        arlen_q, arlen_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ar_hs, r_hs, retire, underflow;
    logic [4:0]        cur_len, next_len;

    // Sized from the next-cycle address/remaining so the registered AR fields are ready
    // the cycle after a handshake, giving back-to-back bursts with no bubble.
    dma_burst_sizer #(
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST)
    ) u_sizer (
        .beat_idx  (addr_d[11:3]),
        .remaining (remaining_d),
        .len       (next_len)
    );

    always_comb begin
        // NOTE: every _d gets a default first, so no path through the case can infer a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;

        ar_hs     = arvalid_q & axi.m_axi_acp_arready;
        r_hs      = axi.m_axi_acp_rvalid & axi.m_axi_acp_rready;
        retire    = r_hs & axi.m_axi_acp_rlast;
        underflow = retire & ~ar_hs & (outstanding_q == 4'd0);
        cur_len   = {1'b0, arlen_q} + 5'd1;

        if (ar_hs && !retire) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (retire && !ar_hs && outstanding_q != 4'd0) begin
            outstanding_d = outstanding_q - 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr & ~ADDR_W'(BEAT_BYTES - 1);
                    remaining_d = cmd_beats;
                    err_d       = 1'b0;
                    state_d     = (cmd_beats == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (ar_hs) begin
                    addr_d      = addr_q + ADDR_W'(cur_len) * ADDR_W'(BEAT_BYTES);
                    remaining_d = remaining_q - LEN_W'(cur_len);
                end
                if (remaining_d == '0) begin
                    state_d = (outstanding_d == 4'd0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_d == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((r_hs && axi.m_axi_acp_rresp != AXI_RESP_OKAY) || underflow) begin
            err_d = 1'b1;
        end
    end

    // Outputs are registered from the next state, so they change exactly on the edge
    // that moves the FSM.
    always_comb begin
        arvalid_d   = (state_d == ISSUE) && (outstanding_d < 4'(MAX_OUTSTANDING));
        araddr_d    = addr_d;
        arlen_d     = 4'(next_len - 5'd1);
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of its _d regardless of statement order.
    always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign axi.m_axi_acp_araddr  = araddr_q;
    assign axi.m_axi_acp_arlen   = arlen_q;
    assign axi.m_axi_acp_arburst = AXI_BURST_INCR;
    assign axi.m_axi_acp_arvalid = arvalid_q;
    assign cmd_ready             = cmd_ready_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign err                   = err_q;

endmodule

// File: tb/tb_dma_read_scheduler.sv
// Directed bench for dma_read_scheduler: burst splitting, 4 KB crossing, outstanding
// throttle, simultaneous issue/retire, error reporting, zero length and reset abort.
module tb_dma_read_scheduler;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [19:0] cmd_beats;
    logic        busy;
    logic        done;
    logic        err;

    logic [8:0]  sz_idx;
    logic [19:0] sz_rem;
    logic [4:0]  sz_len;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dma_read_scheduler_if #(.ADDR_W(32)) axi ();

    dma_read_scheduler #(
        .ADDR_W          (32),
        .LEN_W           (20),
        .MAX_BURST       (16),
        .MAX_OUTSTANDING (4)
    ) dut (
        .m_axi_acp_aclk (clk),
        .axi_resetn     (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_beats      (cmd_beats),
        .axi            (axi),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    dma_burst_sizer #(
        .LEN_W     (20),
        .MAX_BURST (16)
    ) u_sizer_ut (
        .beat_idx  (sz_idx),
        .remaining (sz_rem),
        .len       (sz_len)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [19:0] beats);
        check("cmd_ready before accept", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_beats = beats;
        step();
        cmd_valid = 1'b0;
    endtask

    // Checks the presented burst at this negedge; the following posedge takes it (arready=1).
    task automatic expect_ar(input string tag, input logic [31:0] addr, input logic [3:0] len);
        check({tag, " arvalid"}, 64'(axi.m_axi_acp_arvalid), 64'd1);
        check({tag, " araddr"},  64'(axi.m_axi_acp_araddr),  64'(addr));
        check({tag, " arlen"},   64'(axi.m_axi_acp_arlen),   64'(len));
        step();
    endtask

    task automatic r_burst(input int n, input int err_beat);
        for (int i = 0; i < n; i++) begin
            axi.m_axi_acp_rvalid = 1'b1;
            axi.m_axi_acp_rready = 1'b1;
            axi.m_axi_acp_rlast  = (i == n - 1);
            axi.m_axi_acp_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            step();
        end
        axi.m_axi_acp_rvalid = 1'b0;
        axi.m_axi_acp_rready = 1'b0;
        axi.m_axi_acp_rlast  = 1'b0;
        axi.m_axi_acp_rresp  = 2'b00;
    endtask

    task automatic expect_done(input string tag, input logic exp_err);
        check({tag, " done pulse"},     64'(done),      64'd1);
        check({tag, " err"},            64'(err),       64'(exp_err));
        check({tag, " busy with done"}, 64'(busy),      64'd1);
        step();
        check({tag, " done cleared"},   64'(done),      64'd0);
        check({tag, " busy fallen"},    64'(busy),      64'd0);
        check({tag, " cmd_ready back"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        rst_n                 = 1'b0;
        cmd_valid             = 1'b0;
        cmd_addr              = '0;
        cmd_beats             = '0;
        axi.m_axi_acp_arready = 1'b0;
        axi.m_axi_acp_rvalid  = 1'b0;
        axi.m_axi_acp_rready  = 1'b0;
        axi.m_axi_acp_rlast   = 1'b0;
        axi.m_axi_acp_rresp   = 2'b00;

        // Sizer unit vectors: min(remaining, 16, 512 - beat_idx)
        sz_idx = 9'd0;   sz_rem = 20'd40;  #1 check("sizer max burst", 64'(sz_len), 64'd16);
        sz_idx = 9'd504; sz_rem = 20'd20;  #1 check("sizer boundary 8", 64'(sz_len), 64'd8);
        sz_idx = 9'd511; sz_rem = 20'd100; #1 check("sizer boundary 1", 64'(sz_len), 64'd1);
        sz_idx = 9'd0;   sz_rem = 20'd5;   #1 check("sizer remaining 5", 64'(sz_len), 64'd5);
        sz_idx = 9'd500; sz_rem = 20'd12;  #1 check("sizer tie 12", 64'(sz_len), 64'd12);

        repeat (2) step();
        check("reset cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset busy",      64'(busy),      64'd0);
        check("reset done",      64'(done),      64'd0);
        check("reset err",       64'(err),       64'd0);
        check("reset arvalid",   64'(axi.m_axi_acp_arvalid), 64'd0);
        check("reset araddr",    64'(axi.m_axi_acp_araddr),  64'd0);
        check("reset arlen",     64'(axi.m_axi_acp_arlen),   64'd0);
        check("arburst incr",    64'(axi.m_axi_acp_arburst), 64'd1);
        rst_n = 1'b1;
        step();

        // Basic transfer: 40 beats -> 16 + 16 + 8
        axi.m_axi_acp_arready = 1'b1;
        send_cmd(32'h1000_0000, 20'd40);
        check("basic busy", 64'(busy), 64'd1);
        check("basic cmd_ready low", 64'(cmd_ready), 64'd0);
        expect_ar("basic ar0", 32'h1000_0000, 4'd15);
        expect_ar("basic ar1", 32'h1000_0080, 4'd15);
        expect_ar("basic ar2", 32'h1000_0100, 4'd7);
        check("basic drain arvalid", 64'(axi.m_axi_acp_arvalid), 64'd0);
        r_burst(16, -1);
        check("basic no early done 1", 64'(done), 64'd0);
        r_burst(16, -1);
        check("basic no early done 2", 64'(done), 64'd0);
        r_burst(8, -1);
        expect_done("basic", 1'b0);

        // 4 KB crossing: 0xFC0 has 8 beats to the boundary
        send_cmd(32'h0000_0FC0, 20'd20);
        expect_ar("cross ar0", 32'h0000_0FC0, 4'd7);
        expect_ar("cross ar1", 32'h0000_1000, 4'd11);
        check("cross drain arvalid", 64'(axi.m_axi_acp_arvalid), 64'd0);
        r_burst(8, -1);
        r_burst(12, -1);
        expect_done("cross", 1'b0);

        // Outstanding limit: 10 bursts, only 4 in flight at once
        send_cmd(32'h2000_0000, 20'd160);
        for (int k = 0; k < 4; k++) begin
            expect_ar($sformatf("limit ar%0d", k), 32'h2000_0000 + 32'(k) * 32'h80, 4'd15);
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("limit stalled %0d", k), 64'(axi.m_axi_acp_arvalid), 64'd0);
            step();
        end
        for (int k = 4; k < 10; k++) begin
            r_burst(1, -1);
            expect_ar($sformatf("limit ar%0d", k), 32'h2000_0000 + 32'(k) * 32'h80, 4'd15);
            check($sformatf("limit single ar%0d", k), 64'(axi.m_axi_acp_arvalid), 64'd0);
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("limit drain done %0d", j), 64'(done), 64'd0);
            r_burst(1, -1);
        end
        expect_done("limit", 1'b0);

        // Simultaneous AR handshake and retire every cycle from the second burst on
        send_cmd(32'h3000_0000, 20'd160);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("simul ar%0d arvalid", k), 64'(axi.m_axi_acp_arvalid), 64'd1);
            check($sformatf("simul ar%0d araddr", k), 64'(axi.m_axi_acp_araddr),
                  64'(32'h3000_0000 + 32'(k) * 32'h80));
            axi.m_axi_acp_rvalid = (k >= 1);
            axi.m_axi_acp_rready = (k >= 1);
            axi.m_axi_acp_rlast  = (k >= 1);
            step();
        end
        check("simul drain arvalid", 64'(axi.m_axi_acp_arvalid), 64'd0);
        check("simul no early done", 64'(done), 64'd0);
        step();
        axi.m_axi_acp_rvalid = 1'b0;
        axi.m_axi_acp_rready = 1'b0;
        axi.m_axi_acp_rlast  = 1'b0;
        expect_done("simul", 1'b0);

        // Error on a middle beat, then a zero-length command clears it
        send_cmd(32'h4000_0000, 20'd24);
        expect_ar("error ar0", 32'h4000_0000, 4'd15);
        expect_ar("error ar1", 32'h4000_0080, 4'd7);
        r_burst(16, 5);
        r_burst(8, -1);
        expect_done("error", 1'b1);
        send_cmd(32'h5000_0000, 20'd0);
        check("zero arvalid", 64'(axi.m_axi_acp_arvalid), 64'd0);
        expect_done("zero", 1'b0);
        check("zero still no arvalid", 64'(axi.m_axi_acp_arvalid), 64'd0);

        // Reset while an AR is stalled
        axi.m_axi_acp_arready = 1'b0;
        send_cmd(32'h6000_0000, 20'd32);
        check("stall arvalid", 64'(axi.m_axi_acp_arvalid), 64'd1);
        check("stall araddr",  64'(axi.m_axi_acp_araddr),  64'h6000_0000);
        step();
        check("stall hold arvalid", 64'(axi.m_axi_acp_arvalid), 64'd1);
        check("stall hold araddr",  64'(axi.m_axi_acp_araddr),  64'h6000_0000);
        check("stall hold arlen",   64'(axi.m_axi_acp_arlen),   64'd15);
        #2 rst_n = 1'b0;
        #1;
        check("abort arvalid",   64'(axi.m_axi_acp_arvalid), 64'd0);
        check("abort busy",      64'(busy),      64'd0);
        check("abort done",      64'(done),      64'd0);
        check("abort cmd_ready", 64'(cmd_ready), 64'd1);
        step();
        rst_n = 1'b1;
        axi.m_axi_acp_arready = 1'b1;
        step();
        send_cmd(32'h7000_0105, 20'd16);
        expect_ar("after reset ar0", 32'h7000_0100, 4'd15);
        check("after reset single ar", 64'(axi.m_axi_acp_arvalid), 64'd0);
        r_burst(16, -1);
        expect_done("after reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
